exp_job_sequencer: RTL and testbench

Job front-end for the exponentiation datapath.
- Buffers fixed-point exponents x from a producer in a small FIFO.
- Launches one exponentiation at a time using the start/busy/done handshake.
- Captures the {integer, fraction} result into a holding register and presents it downstream on a valid/ready interface.
- Sits between the operand source and the exponentiation block, and between that block and the result consumer.

---
 rtl/exp_job_sequencer_if.sv | 33 +++
 rtl/exp_job_sequencer.sv | 139 +++++++++++++
 tb/tb_exp_job_sequencer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/exp_job_sequencer_if.sv
// Handshake bundle between the job sequencer, its operand producer,
// the exponentiation block and the result consumer.
interface exp_job_sequencer_if #(
  parameter int F_WIDTH   = 16,
  parameter int PTR_WIDTH = 2
);
  logic                 in_valid;
  logic                 in_ready;
  logic [F_WIDTH-1:0]   in_x;
  logic                 exp_start;
  logic [F_WIDTH-1:0]   exp_x;
  logic                 exp_busy;
  logic                 exp_done;
  logic [1:0]           exp_i_part;
  logic [F_WIDTH-1:0]   exp_f_part;
  logic                 out_valid;
  logic                 out_ready;
  logic [F_WIDTH+1:0]   out_data;
  logic [PTR_WIDTH:0]   pending;
  logic                 idle;

  // Sequencer view.
  modport master (
    input  in_valid, in_x, exp_busy, exp_done, exp_i_part, exp_f_part, out_ready,
    output in_ready, exp_start, exp_x, out_valid, out_data, pending, idle
  );

  // Environment view: producer, exponentiation block and consumer.
  modport slave (
    output in_valid, in_x, exp_busy, exp_done, exp_i_part, exp_f_part, out_ready,
    input  in_ready, exp_start, exp_x, out_valid, out_data, pending, idle
  );
endinterface

// File: rtl/exp_job_sequencer.sv
// Job front-end for the exponentiation datapath: operand FIFO, single-job
// launch FSM and a one-entry result holding register with valid/ready output.
module exp_job_sequencer #(
  parameter int F_WIDTH   = 16,
  parameter int DEPTH     = 4,
  parameter int PTR_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  exp_job_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_e;

  logic [F_WIDTH-1:0]   mem_q [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH:0]   count_q, count_d;
  state_e               state_q, state_d;
  logic                 exp_start_q, exp_start_d;
  logic [F_WIDTH-1:0]   exp_x_q, exp_x_d;
  logic                 out_valid_q, out_valid_d;
  logic [F_WIDTH+1:0]   out_data_q, out_data_d;
  logic                 in_ready_q, in_ready_d;
  logic                 idle_q, idle_d;
  logic                 push_s, pop_s, capture_s;

  always_comb begin
    push_s      = bus.in_valid && in_ready_q;
    pop_s       = 1'b0;
    capture_s   = 1'b0;
    state_d     = state_q;
    exp_start_d = exp_start_q;
    exp_x_d     = exp_x_q;

    case (state_q)
      S_IDLE: begin
        if ((count_q != '0) && !bus.exp_busy) begin
          pop_s       = 1'b1;
          exp_x_d     = mem_q[rd_ptr_q];
          exp_start_d = 1'b1;
          state_d     = S_LAUNCH;
        end else begin
          exp_start_d = 1'b0;
        end
      end
      S_LAUNCH: begin
        if (bus.exp_busy) begin
          exp_start_d = 1'b0;
          state_d     = S_WAIT_DONE;
        end else begin
          exp_start_d = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        // A full, unread holding register stalls capture; exp_done stays high meanwhile.
        if (bus.exp_done && (!out_valid_q || bus.out_ready)) begin
          capture_s = 1'b1;
          state_d   = S_IDLE;
        end else begin
          state_d   = S_WAIT_DONE;
        end
      end
      default: begin
        exp_start_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase

    if (capture_s) begin
      out_valid_d = 1'b1;
      out_data_d  = {bus.exp_i_part, bus.exp_f_part};
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
    end else begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
    end

    wr_ptr_d = push_s ? (wr_ptr_q + PTR_WIDTH'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_WIDTH'(1)) : rd_ptr_q;

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (PTR_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (PTR_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase

    in_ready_d = (count_d != (PTR_WIDTH+1)'(DEPTH));
    idle_d     = (count_d == '0) && (state_d == S_IDLE) && !out_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
      exp_start_q <= 1'b0;
      exp_x_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b1;
      idle_q      <= 1'b1;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      exp_start_q <= exp_start_d;
      exp_x_q     <= exp_x_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      idle_q      <= idle_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= bus.in_x;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.exp_start = exp_start_q;
  assign bus.exp_x     = exp_x_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.pending   = count_q;
  assign bus.idle      = idle_q;

endmodule

// File: tb/tb_exp_job_sequencer.sv
// Directed bench for exp_job_sequencer with a behavioural exponentiation block
// and a launch/result scoreboard.
module tb_exp_job_sequencer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  exp_job_sequencer_if #(.F_WIDTH(16), .PTR_WIDTH(2)) bus ();

  exp_job_sequencer #(.F_WIDTH(16), .DEPTH(4), .PTR_WIDTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in result: any fixed bijection of x serves, since the sequencer only transports it.
  function automatic logic [17:0] exp_res(input logic [15:0] x);
    return {x[15:14] ^ 2'b11, x ^ 16'h2612};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Exponentiation block model: busy the edge after start, done 10 edges later.
  logic        m_busy, m_done, force_busy;
  int          m_cnt;
  logic [15:0] m_x;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_cnt <= 0; m_x <= 16'h0000;
    end else if (bus.exp_start && !m_busy) begin
      m_busy <= 1'b1; m_done <= 1'b0; m_cnt <= 10; m_x <= bus.exp_x;
    end else if (m_busy) begin
      if (m_cnt == 1) begin m_busy <= 1'b0; m_done <= 1'b1; end
      else m_cnt <= m_cnt - 1;
    end
  end
  assign bus.exp_busy   = m_busy | force_busy;
  assign bus.exp_done   = m_done;
  assign bus.exp_i_part = exp_res(m_x)[17:16];
  assign bus.exp_f_part = exp_res(m_x)[15:0];

  // Scoreboard: launches must follow accepted order, results must follow launches.
  logic [15:0] exp_q [$];
  logic [17:0] res_q [$];
  logic        start_prev;
  logic [15:0] xe;
  always @(negedge clk) begin
    if (rst) begin
      start_prev <= 1'b0;
    end else begin
      if (bus.exp_start && !start_prev) begin
        if (exp_q.size() == 0) check_eq("launch_unexpected", 32'd1, 32'd0);
        else begin
          xe = exp_q.pop_front();
          check_eq("launch_x", bus.exp_x, xe);
          res_q.push_back(exp_res(xe));
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        if (res_q.size() == 0) check_eq("result_unexpected", 32'd1, 32'd0);
        else check_eq("result_data", bus.out_data, res_q.pop_front());
      end
      start_prev <= bus.exp_start;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] x);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_x     = x;
    while (!bus.in_ready && n < 100) begin step(); n++; end
    check_eq("push_ready", bus.in_ready, 32'd1);
    step();
    exp_q.push_back(x);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!bus.idle && n < 200) begin step(); n++; end
    check_eq(tag, bus.idle, 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!bus.exp_done && n < 100) begin step(); n++; end
    check_eq(tag, bus.exp_done, 32'd1);
  endtask

  task automatic wait_out_valid(input string tag);
    int n = 0;
    while (!bus.out_valid && n < 100) begin step(); n++; end
    check_eq(tag, bus.out_valid, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] vals [10];
    n_checks = 0; n_pass = 0;
    rst = 1'b1; force_busy = 1'b0;
    bus.in_valid = 1'b0; bus.in_x = 16'h0000; bus.out_ready = 1'b0;
    step(); step();
    check_eq("rst_exp_start", bus.exp_start, 32'd0);
    check_eq("rst_exp_x", bus.exp_x, 32'd0);
    check_eq("rst_out_valid", bus.out_valid, 32'd0);
    check_eq("rst_out_data", bus.out_data, 32'd0);
    check_eq("rst_pending", bus.pending, 32'd0);
    check_eq("rst_in_ready", bus.in_ready, 32'd1);
    check_eq("rst_idle", bus.idle, 32'd1);
    rst = 1'b0;
    step();

    // Single job with exact handshake timing.
    bus.in_valid = 1'b1; bus.in_x = 16'h8000;
    step();
    exp_q.push_back(16'h8000);
    bus.in_valid = 1'b0;
    check_eq("sj_pending_push", bus.pending, 32'd1);
    check_eq("sj_start_early", bus.exp_start, 32'd0);
    check_eq("sj_idle_busy", bus.idle, 32'd0);
    step();
    check_eq("sj_start_high", bus.exp_start, 32'd1);
    check_eq("sj_exp_x", bus.exp_x, 32'h8000);
    check_eq("sj_pending_pop", bus.pending, 32'd0);
    step();
    check_eq("sj_start_hold", bus.exp_start, 32'd1);
    check_eq("sj_busy_seen", bus.exp_busy, 32'd1);
    step();
    check_eq("sj_start_drop", bus.exp_start, 32'd0);
    wait_out_valid("sj_out_valid");
    check_eq("sj_out_data", bus.out_data, 32'h1A612);
    check_eq("sj_idle_held", bus.idle, 32'd0);
    step(); step(); step();
    check_eq("sj_out_data_stable", bus.out_data, 32'h1A612);
    bus.out_ready = 1'b1;
    step();
    check_eq("sj_out_valid_clr", bus.out_valid, 32'd0);
    check_eq("sj_idle_back", bus.idle, 32'd1);

    // FIFO full: the fifth back-to-back offer is refused.
    force_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_x = 16'h1100 + 16'(i);
      check_eq("full_in_ready", bus.in_ready, (i < 4) ? 32'd1 : 32'd0);
      step();
      if (i < 4) exp_q.push_back(16'h1100 + 16'(i));
    end
    bus.in_valid = 1'b0;
    check_eq("full_pending", bus.pending, 32'd4);
    force_busy = 1'b0;
    wait_idle("full_drain_idle");

    // Push/pop collisions at occupancy 4 and 2.
    force_busy = 1'b1;
    for (int i = 0; i < 4; i++) push(16'h2200 + 16'(i));
    check_eq("col_pending4", bus.pending, 32'd4);
    check_eq("col_in_ready4", bus.in_ready, 32'd0);
    bus.in_valid = 1'b1; bus.in_x = 16'h0D0D; force_busy = 1'b0;
    step();
    bus.in_valid = 1'b0; force_busy = 1'b1;
    check_eq("col_pending3", bus.pending, 32'd3);
    check_eq("col_in_ready3", bus.in_ready, 32'd1);
    step(); step();
    wait_done("col_done_a");
    step(); step();
    force_busy = 1'b0;
    step();
    force_busy = 1'b1;
    check_eq("col_pending2_pre", bus.pending, 32'd2);
    step(); step();
    wait_done("col_done_b");
    step(); step();
    bus.in_valid = 1'b1; bus.in_x = 16'h0E0E; force_busy = 1'b0;
    step();
    exp_q.push_back(16'h0E0E);
    bus.in_valid = 1'b0;
    check_eq("col_pending2", bus.pending, 32'd2);
    check_eq("col_popped", bus.exp_start, 32'd1);
    wait_idle("col_drain_idle");

    // Output stall: second result waits until the first is read.
    bus.out_ready = 1'b0;
    push(16'h3A3A);
    push(16'h3B3B);
    wait_out_valid("stall_first_valid");
    check_eq("stall_first_data", bus.out_data, exp_res(16'h3A3A));
    for (int i = 0; i < 30; i++) step();
    check_eq("stall_held_valid", bus.out_valid, 32'd1);
    check_eq("stall_held_data", bus.out_data, exp_res(16'h3A3A));
    check_eq("stall_second_done", bus.exp_done, 32'd1);
    check_eq("stall_not_idle", bus.idle, 32'd0);
    bus.out_ready = 1'b1;
    step();
    check_eq("stall_swap_valid", bus.out_valid, 32'd1);
    check_eq("stall_swap_data", bus.out_data, exp_res(16'h3B3B));
    step();
    check_eq("stall_final_clr", bus.out_valid, 32'd0);

    // Pointer wrap over ten jobs.
    for (int i = 0; i < 10; i++) vals[i] = 16'h4000 + 16'(i * 16'h0123);
    for (int i = 0; i < 10; i++) push(vals[i]);
    wait_idle("wrap_idle");
    check_eq("wrap_launch_left", exp_q.size(), 32'd0);
    check_eq("wrap_result_left", res_q.size(), 32'd0);

    // Reset while one job is in flight and three are buffered.
    for (int i = 0; i < 4; i++) push(16'h5500 + 16'(i));
    check_eq("rstmid_pending_pre", bus.pending, 32'd3);
    check_eq("rstmid_busy_pre", bus.exp_busy, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("rstmid_pending", bus.pending, 32'd0);
    check_eq("rstmid_exp_start", bus.exp_start, 32'd0);
    check_eq("rstmid_out_valid", bus.out_valid, 32'd0);
    check_eq("rstmid_idle", bus.idle, 32'd1);
    check_eq("rstmid_in_ready", bus.in_ready, 32'd1);
    exp_q.delete();
    res_q.delete();
    step(); step();
    rst = 1'b0;
    step();
    push(16'h6666);
    wait_idle("rstmid_fresh_idle");
    check_eq("rstmid_fresh_launch", exp_q.size(), 32'd0);
    check_eq("rstmid_fresh_result", res_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
